datapath: RTL and testbench
===========================

# datapath

Single-bus 32-bit CPU datapath used by the phase-1 instruction-level benches. It holds general registers R2–R7, plus PC, IR, MAR, MDR, Y, Z (64-bit, split Hi/Lo), HI and LO, all sharing one combinational bus. An external control sequence moves values across the bus and computes through an adder ALU. There is no internal controller; every transfer is commanded by the in/out strobes.

## Interface
Parameters: none.

Ports (name, direction, width, meaning):
- clock  in  1  single system clock; all registers update on its rising edge
- clear  in  1  synchronous, active-high reset
- Mdatain  in  32  memory read data, into MDR
- MDRread  in  1  MDR input select: 1 = Mdatain, 0 = bus
- MDRin, MARin, PCin, IRin, RYin, RZinLo, RZinHi, LOin, HIin  in  1 each  load enables
- R2in … R7in  in  1 each  general register load enables
- PCout, MDRout, MARout, IRout, RYout, RZoutLo, RZoutHi  in  1 each  bus drive enables
- R2out … R7out  in  1 each  general register bus drive enables
- IncPC  in  1  ALU mode: result = bus + 1
- BusMuxOut  out  32  current bus value (observation)
- Address  out  32  MAR contents (memory address)

## Operation
- Bus is a combinational mux. When several drivers are asserted, the first in this priority order wins: R2out, R3out, R4out, R5out, R6out, R7out, PCout, MDRout, MARout, IRout, RYout, RZoutHi, RZoutLo.
- With no driver asserted, the bus is 0.
- Register loads on a rising clock edge when their enable is high:
  - General registers, PC, IR, MAR, Y, HI and LO load from the bus.
  - MDR loads Mdatain if MDRread = 1, else the bus.
- Register outputs:
  - A register's bus input is its stored value.
  - IR drives the full 32-bit word.
  - RZoutLo drives Z[31:0]; RZoutHi drives Z[63:32].
- ALU (combinational, 64-bit result):
  - IncPC = 1: result = {32'b0, bus} + 1.
  - IncPC = 0: result = zero-extended Y + zero-extended bus. The carry lands in bit 32 and bits 63:33 are 0.
- Z loading: RZinLo loads result[31:0] into Z[31:0]; RZinHi loads result[63:32] into Z[63:32]. The two halves load independently, or together when both are set.
- IncPC does not modify PC directly. PC changes only through PCin.
- Address = MAR at all times.
- clear = 1 at a rising edge zeroes every register: R2–R7, PC, IR, MAR, MDR, Y, Z, HI, LO.
  - clear overrides all simultaneous load enables.
  - It is valid mid-sequence; the next edge after clear deasserts resumes normal loads.

## Timing
- Every register transfer takes one clock: a source drives, the destination's in strobe is set, and the value is captured at the next rising edge.
- Bus and ALU are combinational, with no added latency.
- Read-then-write in the same cycle: a register both driving the bus and loading captures the pre-edge bus value, so it holds itself unchanged.
- Control inputs are sampled only at rising edges. Mid-cycle changes that do not straddle an edge have no effect.
- Reset values after clear:
  - All registers 0.
  - BusMuxOut = 0 when no driver is asserted.
  - Address = 0.
- Typical add sequence (T0–T5, six cycles from instruction fetch to writeback):
  - T0: PCout, MARin, IncPC, RZinLo.
  - T1: MDRread, MDRin, Mdatain = instruction.
  - T2: MDRout, IRin.
  - T3: Rs out, RYin.
  - T4: Rt out, RZinLo.
  - T5: RZoutLo, Rd in.

## Test plan
- Reset: drive clear = 1 for one edge with all enables high and R3 preloaded with 0x55. Required response: R3, MAR, Z are all 0, Address = 0, BusMuxOut = 0.
- Register load via MDR:
  - Mdatain = 0x22, then MDRread/MDRin for one edge, then MDRout/R3in for one edge → R3 = 0x22.
  - Repeat the same sequence with 0x24 into R7 and 0x28 into R4.
- Add R4, R3, R7, starting from the loads above:
  - T0 → MAR = 0, Z[31:0] = 1.
  - T1–T2 with Mdatain = 0x1A2B8000 → IR = 0x1A2B8000.
  - T3 → Y = 0x22.
  - T4 → Z[31:0] = 0x46.
  - T5 → R4 = 0x46.
- Carry/Hi: Y = 0xFFFFFFFF, bus = 2, RZinLo and RZinHi set → Z[31:0] = 1, Z[63:32] = 1. RZoutHi then drives 1 onto the bus.
- Bus priority and idle bus:
  - R2 = 5, R3 = 9, R2out and R3out asserted together → BusMuxOut = 5.
  - No drivers asserted → BusMuxOut = 0.
- HI/LO: R6 = 0x1234 driven with HIin, then with LOin → both hold 0x1234. Toggling control inputs mid-cycle with no edge leaves them unchanged.

Source files
------------

// File: rtl/datapath.sv
// Single-bus 32-bit CPU datapath: general registers R2-R7, PC, IR, MAR, MDR,
// Y, 64-bit Z (split Hi/Lo), HI and LO, all sharing one combinational bus.
// An external control sequence drives the in/out strobes; an adder ALU
// (bus + 1, or Y + bus with the carry in bit 32) feeds the two halves of Z.
module datapath (
  input  logic        clock,
  input  logic        clear,
  input  logic [31:0] Mdatain,
  input  logic        MDRread,
  input  logic        MDRin,
  input  logic        MARin,
  input  logic        PCin,
  input  logic        IRin,
  input  logic        RYin,
  input  logic        RZinLo,
  input  logic        RZinHi,
  input  logic        LOin,
  input  logic        HIin,
  input  logic        R2in,
  input  logic        R3in,
  input  logic        R4in,
  input  logic        R5in,
  input  logic        R6in,
  input  logic        R7in,
  input  logic        PCout,
  input  logic        MDRout,
  input  logic        MARout,
  input  logic        IRout,
  input  logic        RYout,
  input  logic        RZoutLo,
  input  logic        RZoutHi,
  input  logic        R2out,
  input  logic        R3out,
  input  logic        R4out,
  input  logic        R5out,
  input  logic        R6out,
  input  logic        R7out,
  input  logic        IncPC,
  output logic [31:0] BusMuxOut,
  output logic [31:0] Address
);

  logic [31:0] gpr_q [2:7];
  logic [31:0] gpr_d [2:7];
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] mar_q, mar_d;
  logic [31:0] mdr_q, mdr_d;
  logic [31:0] y_q, y_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [63:0] z_q, z_d;

  logic [7:2]  gprIn;
  logic [63:0] aluResult;

  assign gprIn   = {R7in, R6in, R5in, R4in, R3in, R2in};
  assign Address = mar_q;

  // Bus mux: the first asserted driver in the fixed priority order wins,
  // and an undriven bus reads as zero.
  always_comb begin
    BusMuxOut = '0;
    if      (R2out)   BusMuxOut = gpr_q[2];
    else if (R3out)   BusMuxOut = gpr_q[3];
    else if (R4out)   BusMuxOut = gpr_q[4];
    else if (R5out)   BusMuxOut = gpr_q[5];
    else if (R6out)   BusMuxOut = gpr_q[6];
    else if (R7out)   BusMuxOut = gpr_q[7];
    else if (PCout)   BusMuxOut = pc_q;
    else if (MDRout)  BusMuxOut = mdr_q;
    else if (MARout)  BusMuxOut = mar_q;
    else if (IRout)   BusMuxOut = ir_q;
    else if (RYout)   BusMuxOut = y_q;
    else if (RZoutHi) BusMuxOut = z_q[63:32];
    else if (RZoutLo) BusMuxOut = z_q[31:0];
  end

  // Adder ALU: increment mode for PC stepping, otherwise Y + bus with the
  // carry out landing in bit 32 of the 64-bit result.
  always_comb begin
    if (IncPC) aluResult = {32'b0, BusMuxOut} + 64'd1;
    else       aluResult = {32'b0, y_q} + {32'b0, BusMuxOut};
  end

  // Next-state selection: each register takes the bus (or Mdatain / ALU
  // result) when its load enable is set and otherwise holds its value.
  always_comb begin
    for (int i = 2; i <= 7; i++) begin
      gpr_d[i] = gprIn[i] ? BusMuxOut : gpr_q[i];
    end
    pc_d  = PCin  ? BusMuxOut : pc_q;
    ir_d  = IRin  ? BusMuxOut : ir_q;
    mar_d = MARin ? BusMuxOut : mar_q;
    y_d   = RYin  ? BusMuxOut : y_q;
    hi_d  = HIin  ? BusMuxOut : hi_q;
    lo_d  = LOin  ? BusMuxOut : lo_q;
    mdr_d = mdr_q;
    if (MDRin) mdr_d = MDRread ? Mdatain : BusMuxOut;
    z_d = z_q;
    if (RZinLo) z_d[31:0]  = aluResult[31:0];
    if (RZinHi) z_d[63:32] = aluResult[63:32];
  end

  // Register file update: clear zeroes everything and overrides any load.
  always_ff @(posedge clock) begin
    if (clear) begin
      for (int i = 2; i <= 7; i++) begin
        gpr_q[i] <= '0;
      end
      pc_q  <= '0;
      ir_q  <= '0;
      mar_q <= '0;
      mdr_q <= '0;
      y_q   <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
      z_q   <= '0;
    end else begin
      for (int i = 2; i <= 7; i++) begin
        gpr_q[i] <= gpr_d[i];
      end
      pc_q  <= pc_d;
      ir_q  <= ir_d;
      mar_q <= mar_d;
      mdr_q <= mdr_d;
      y_q   <= y_d;
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      z_q   <= z_d;
    end
  end

endmodule

// File: tb/tb_datapath.sv
// Self-checking bench for datapath: directed test-plan sequences plus a
// randomized phase, all checked against a register-transfer level model of
// the datapath kept in the bench, with literal expectations on key steps.
module tb_datapath;

  logic        clock;
  logic        clear;
  logic [31:0] Mdatain;
  logic        MDRread, MDRin, MARin, PCin, IRin, RYin, RZinLo, RZinHi, LOin, HIin;
  logic        PCout, MDRout, MARout, IRout, RYout, RZoutLo, RZoutHi, IncPC;
  logic [7:2]  rIn, rOut;
  wire  [31:0] BusMuxOut;
  wire  [31:0] Address;

  // Model state: the architectural contents of every register.
  logic [31:0] mR [2:7];
  logic [31:0] mPc, mIr, mMar, mMdr, mY, mHi, mLo;
  logic [63:0] mZ;

  // Literal expectations for the current cycle, set by the directed sequences.
  bit          checkEn;
  bit          litBusValid, litAddrValid;
  logic [31:0] litBus, litAddr;
  string       litName;

  int vectors;
  int miscompares;

  datapath dut (
    .clock    (clock),
    .clear    (clear),
    .Mdatain  (Mdatain),
    .MDRread  (MDRread),
    .MDRin    (MDRin),
    .MARin    (MARin),
    .PCin     (PCin),
    .IRin     (IRin),
    .RYin     (RYin),
    .RZinLo   (RZinLo),
    .RZinHi   (RZinHi),
    .LOin     (LOin),
    .HIin     (HIin),
    .R2in     (rIn[2]),
    .R3in     (rIn[3]),
    .R4in     (rIn[4]),
    .R5in     (rIn[5]),
    .R6in     (rIn[6]),
    .R7in     (rIn[7]),
    .PCout    (PCout),
    .MDRout   (MDRout),
    .MARout   (MARout),
    .IRout    (IRout),
    .RYout    (RYout),
    .RZoutLo  (RZoutLo),
    .RZoutHi  (RZoutHi),
    .R2out    (rOut[2]),
    .R3out    (rOut[3]),
    .R4out    (rOut[4]),
    .R5out    (rOut[5]),
    .R6out    (rOut[6]),
    .R7out    (rOut[7]),
    .IncPC    (IncPC),
    .BusMuxOut(BusMuxOut),
    .Address  (Address)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // What the bus must carry: the highest-priority asserted source, else 0.
  function automatic logic [31:0] expBus();
    for (int i = 2; i <= 7; i++) begin
      if (rOut[i]) return mR[i];
    end
    if (PCout)   return mPc;
    if (MDRout)  return mMdr;
    if (MARout)  return mMar;
    if (IRout)   return mIr;
    if (RYout)   return mY;
    if (RZoutHi) return mZ[63:32];
    if (RZoutLo) return mZ[31:0];
    return 32'h0;
  endfunction

  // Apply one clock edge's worth of register transfers to the model.
  task automatic modelUpdate();
    logic [31:0] b;
    logic [63:0] sum;
    b = expBus();
    if (IncPC) sum = {32'b0, b} + 64'd1;
    else       sum = {32'b0, mY} + {32'b0, b};
    if (clear) begin
      for (int i = 2; i <= 7; i++) mR[i] = '0;
      mPc = '0; mIr = '0; mMar = '0; mMdr = '0; mY = '0; mHi = '0; mLo = '0; mZ = '0;
    end else begin
      for (int i = 2; i <= 7; i++) begin
        if (rIn[i]) mR[i] = b;
      end
      if (PCin)   mPc = b;
      if (IRin)   mIr = b;
      if (MARin)  mMar = b;
      if (RYin)   mY = b;
      if (HIin)   mHi = b;
      if (LOin)   mLo = b;
      if (MDRin)  mMdr = MDRread ? Mdatain : b;
      if (RZinLo) mZ[31:0] = sum[31:0];
      if (RZinHi) mZ[63:32] = sum[63:32];
    end
  endtask

  // Compare process: mid low phase of every cycle, DUT vs model and literals.
  always @(negedge clock) begin
    #3;
    if (checkEn) begin
      vectors++;
      if (BusMuxOut !== expBus()) begin
        miscompares++;
        $display("[TB] FAIL model_bus t=%0t: BusMuxOut=%h expected %h", $time, BusMuxOut, expBus());
      end
      vectors++;
      if (Address !== mMar) begin
        miscompares++;
        $display("[TB] FAIL model_addr t=%0t: Address=%h expected %h", $time, Address, mMar);
      end
      if (litBusValid) begin
        vectors++;
        if (BusMuxOut !== litBus) begin
          miscompares++;
          $display("[TB] FAIL %s: BusMuxOut=%h expected %h", litName, BusMuxOut, litBus);
        end
      end
      if (litAddrValid) begin
        vectors++;
        if (Address !== litAddr) begin
          miscompares++;
          $display("[TB] FAIL %s_addr: Address=%h expected %h", litName, Address, litAddr);
        end
      end
    end
  end

  task automatic idleControls();
    clear = 0; Mdatain = '0; MDRread = 0; MDRin = 0; MARin = 0; PCin = 0; IRin = 0;
    RYin = 0; RZinLo = 0; RZinHi = 0; LOin = 0; HIin = 0; PCout = 0; MDRout = 0;
    MARout = 0; IRout = 0; RYout = 0; RZoutLo = 0; RZoutHi = 0; IncPC = 0;
    rIn = '0; rOut = '0;
  endtask

  // Let the current controls take effect at one edge, then return at the
  // following falling edge with everything idle.
  task automatic step();
    @(posedge clock);
    #1 modelUpdate();
    @(negedge clock);
    litBusValid  = 0;
    litAddrValid = 0;
    idleControls();
  endtask

  task automatic expectBus(input string name, input logic [31:0] v);
    litName     = name;
    litBus      = v;
    litBusValid = 1;
  endtask

  task automatic loadViaMdr(input logic [31:0] v, input int idx, input string name);
    Mdatain = v; MDRread = 1; MDRin = 1;
    step();
    MDRout = 1; rIn[idx] = 1;
    step();
    rOut[idx] = 1;
    expectBus(name, v);
    step();
  endtask

  task automatic applyStimulus();
    clear   = ($urandom_range(19) == 0);
    Mdatain = ($urandom_range(3) == 0) ? 32'hFFFF_FFFF : $urandom;
    MDRread = $urandom_range(1);
    IncPC   = $urandom_range(1);
    MDRin = ($urandom_range(2) == 0); MARin = ($urandom_range(2) == 0);
    PCin  = ($urandom_range(2) == 0); IRin  = ($urandom_range(2) == 0);
    RYin  = ($urandom_range(2) == 0); RZinLo = ($urandom_range(2) == 0);
    RZinHi = ($urandom_range(2) == 0); LOin = ($urandom_range(2) == 0);
    HIin  = ($urandom_range(2) == 0);
    PCout = ($urandom_range(5) == 0); MDRout = ($urandom_range(5) == 0);
    MARout = ($urandom_range(5) == 0); IRout = ($urandom_range(5) == 0);
    RYout = ($urandom_range(5) == 0); RZoutLo = ($urandom_range(5) == 0);
    RZoutHi = ($urandom_range(5) == 0);
    for (int i = 2; i <= 7; i++) begin
      rIn[i]  = ($urandom_range(3) == 0);
      rOut[i] = ($urandom_range(7) == 0);
    end
  endtask

  // Main sequence: reset, test-plan transfers, then random traffic.
  initial begin
    vectors = 0;
    miscompares = 0;
    checkEn = 0;
    litBusValid = 0;
    litAddrValid = 0;
    litBus = '0;
    litAddr = '0;
    litName = "";
    idleControls();
    clear = 1;
    step();
    checkEn = 1;

    // Reset with every enable high and R3 holding 0x55 beforehand.
    loadViaMdr(32'h55, 3, "preload_r3");
    clear = 1; MDRread = 1; Mdatain = 32'hDEAD_BEEF;
    MDRin = 1; MARin = 1; PCin = 1; IRin = 1; RYin = 1; RZinLo = 1; RZinHi = 1;
    LOin = 1; HIin = 1; rIn = '1; rOut = '1; PCout = 1; IncPC = 1;
    step();
    expectBus("reset_idle_bus", 32'h0);
    litAddr = 32'h0; litAddrValid = 1;
    step();
    rOut[3] = 1; expectBus("reset_r3", 32'h0);
    step();
    RZoutLo = 1; expectBus("reset_zlo", 32'h0);
    step();

    // Register loads through MDR.
    loadViaMdr(32'h22, 3, "load_r3");
    loadViaMdr(32'h24, 7, "load_r7");
    loadViaMdr(32'h28, 4, "load_r4");

    // add R4, R3, R7
    PCout = 1; MARin = 1; IncPC = 1; RZinLo = 1;
    step();
    RZoutLo = 1; expectBus("t0_zlo", 32'h1);
    litAddr = 32'h0; litAddrValid = 1;
    step();
    MDRread = 1; MDRin = 1; Mdatain = 32'h1A2B_8000;
    step();
    MDRout = 1; IRin = 1;
    step();
    IRout = 1; expectBus("t2_ir", 32'h1A2B_8000);
    step();
    rOut[3] = 1; RYin = 1;
    step();
    RYout = 1; expectBus("t3_y", 32'h22);
    step();
    rOut[7] = 1; RZinLo = 1;
    step();
    RZoutLo = 1; expectBus("t4_zlo", 32'h46);
    step();
    RZoutLo = 1; rIn[4] = 1;
    step();
    rOut[4] = 1; expectBus("t5_r4", 32'h46);
    step();

    // Carry into Z[63:32].
    loadViaMdr(32'hFFFF_FFFF, 5, "load_r5");
    rOut[5] = 1; RYin = 1;
    step();
    loadViaMdr(32'h2, 6, "load_r6");
    rOut[6] = 1; RZinLo = 1; RZinHi = 1;
    step();
    RZoutLo = 1; expectBus("carry_zlo", 32'h1);
    step();
    RZoutHi = 1; expectBus("carry_zhi", 32'h1);
    step();

    // Bus priority and idle bus.
    loadViaMdr(32'h5, 2, "load_r2");
    loadViaMdr(32'h9, 3, "load_r3b");
    rOut[2] = 1; rOut[3] = 1; expectBus("prio_r2_r3", 32'h5);
    step();
    rOut[7] = 1; PCout = 1; MDRout = 1; expectBus("prio_r7_pc", 32'h24);
    step();
    expectBus("idle_bus", 32'h0);
    step();

    // HI/LO loads, then a strobe pulse that never straddles an edge.
    loadViaMdr(32'h1234, 6, "load_r6b");
    rOut[6] = 1; HIin = 1;
    step();
    rOut[6] = 1; LOin = 1;
    step();
    rOut[6] = 1; rIn[5] = 1;
    #2;
    rOut[6] = 0; rIn[5] = 0;
    step();
    rOut[5] = 1; expectBus("glitch_r5", 32'hFFFF_FFFF);
    step();

    // Random traffic.
    for (int n = 0; n < 500; n++) begin
      applyStimulus();
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
